// File: rtl/mc_control.sv
// Multicycle control FSM for the RV64-subset datapath: one instruction in flight,
// outputs decoded from state (ir_write/pc_write also gated by mem_ready).
module mc_control #(
   parameter int CNT_W           = 32,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [6:0]       i_opcode,
   input  logic [2:0]       i_funct3,
   input  logic [6:0]       i_funct7,
   input  logic             i_mem_ready,
   output logic             o_ir_write,
   output logic             o_pc_write,
   output logic             o_pc_write_cond,
   output logic             o_pc_source,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_i_or_d,
   output logic             o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [3:0]       o_alu_ctl,
   output logic             o_reg_write,
   output logic             o_mem_to_reg,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_instr_count
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_MEM_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD   = 4'd5;
   localparam logic [3:0] S_MEM_WB   = 4'd6;
   localparam logic [3:0] S_MEM_WR   = 4'd7;
   localparam logic [3:0] S_ALU_WB   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_HALT     = 4'd10;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0101;

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic [CNT_W-1:0] r_count;
   logic             w_r_ok, w_i_ok, w_is_ld, w_is_sd, w_is_beq, w_retire;
   logic [3:0]       w_r_ctl, w_i_ctl;

   // IR is held by the datapath for the whole instruction, so decode stays live.
   always_comb begin
      w_r_ok  = 1'b0;
      w_r_ctl = ALU_ADD;
      if (i_opcode == OP_R) begin
         if (i_funct7 == 7'b0000000) begin
            case (i_funct3)
               3'b000:  begin w_r_ok = 1'b1; w_r_ctl = ALU_ADD; end
               3'b100:  begin w_r_ok = 1'b1; w_r_ctl = ALU_XOR; end
               3'b110:  begin w_r_ok = 1'b1; w_r_ctl = ALU_OR;  end
               3'b111:  begin w_r_ok = 1'b1; w_r_ctl = ALU_AND; end
               default: w_r_ok = 1'b0;
            endcase
         end else if (i_funct7 == 7'b0100000 && i_funct3 == 3'b000) begin
            w_r_ok  = 1'b1;
            w_r_ctl = ALU_SUB;
         end
      end
   end

   assign w_i_ok   = (i_opcode == OP_I) && (i_funct3 == 3'b000 || i_funct3 == 3'b110);
   assign w_i_ctl  = (i_funct3 == 3'b110) ? ALU_OR : ALU_ADD;
   assign w_is_ld  = (i_opcode == OP_LD);
   assign w_is_sd  = (i_opcode == OP_SD);
   assign w_is_beq = (i_opcode == OP_B) && (i_funct3 == 3'b000);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (i_mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            if (w_r_ok)                 w_next = S_EXEC_R;
            else if (w_i_ok)            w_next = S_EXEC_I;
            else if (w_is_ld || w_is_sd) w_next = S_MEM_ADDR;
            else if (w_is_beq)          w_next = S_BRANCH;
            else                        w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
         end
         S_EXEC_R:   w_next = S_ALU_WB;
         S_EXEC_I:   w_next = S_ALU_WB;
         S_ALU_WB:   w_next = S_FETCH;
         S_MEM_ADDR: w_next = w_is_ld ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (i_mem_ready) w_next = S_MEM_WB;
         S_MEM_WB:   w_next = S_FETCH;
         S_MEM_WR:   if (i_mem_ready) w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_FETCH;
      endcase
   end

   assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) || (r_state == S_BRANCH) ||
                     ((r_state == S_MEM_WR) && i_mem_ready);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_FETCH;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      o_ir_write      = 1'b0;
      o_pc_write      = 1'b0;
      o_pc_write_cond = 1'b0;
      o_pc_source     = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_i_or_d        = 1'b0;
      o_alu_src_a     = 1'b0;
      o_alu_src_b     = 2'b00;
      o_alu_ctl       = ALU_ADD;
      o_reg_write     = 1'b0;
      o_mem_to_reg    = 1'b0;
      o_halted        = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         S_DECODE:   o_alu_src_b = 2'b10;
         S_EXEC_R: begin
            o_alu_src_a = 1'b1;
            o_alu_ctl   = w_r_ctl;
         end
         S_EXEC_I: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            o_alu_ctl   = w_i_ctl;
         end
         S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            o_mem_read = 1'b1;
            o_i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            o_mem_write = 1'b1;
            o_i_or_d    = 1'b1;
         end
         S_ALU_WB:   o_reg_write = 1'b1;
         S_BRANCH: begin
            o_alu_src_a     = 1'b1;
            o_alu_ctl       = ALU_SUB;
            o_pc_write_cond = 1'b1;
            o_pc_source     = 1'b1;
         end
         S_HALT:     o_halted = 1'b1;
         default:    o_halted = 1'b0;
      endcase
   end

   assign o_instr_count = r_count;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-level model expands each instruction into its
// expected per-cycle control vectors; one negedge process compares DUT against it.
module tb_mc_control;

   typedef struct packed {
      logic       ir_write, pc_write, pc_write_cond, pc_source;
      logic       mem_read, mem_write, i_or_d, alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctl;
      logic       reg_write, mem_to_reg, halted;
   } ctl_t;

   typedef enum int {P_FETCH, P_DECODE, P_EXR, P_EXI, P_MADDR, P_MRD, P_MWB, P_MWR,
                     P_AWB, P_BR, P_HALT} ph_t;

   localparam logic [3:0] ADD = 4'b0010;
   localparam logic [3:0] SUB = 4'b0110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, mem_ready;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   logic       irw0, pcw0, pwc0, pcs0, mrd0, mwr0, iod0, asa0, rgw0, m2r0, hlt0;
   logic [1:0] asb0;
   logic [3:0] alc0;
   logic [31:0] cnt0;
   logic       irw1, pcw1, pwc1, pcs1, mrd1, mwr1, iod1, asa1, rgw1, m2r1, hlt1;
   logic [1:0] asb1;
   logic [3:0] alc1;
   logic [3:0] cnt1;

   mc_control dut0 (
      .i_clk(clk), .i_reset(rst0), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
      .i_mem_ready(mem_ready), .o_ir_write(irw0), .o_pc_write(pcw0), .o_pc_write_cond(pwc0),
      .o_pc_source(pcs0), .o_mem_read(mrd0), .o_mem_write(mwr0), .o_i_or_d(iod0),
      .o_alu_src_a(asa0), .o_alu_src_b(asb0), .o_alu_ctl(alc0), .o_reg_write(rgw0),
      .o_mem_to_reg(m2r0), .o_halted(hlt0), .o_instr_count(cnt0));

   mc_control #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut1 (
      .i_clk(clk), .i_reset(rst1), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
      .i_mem_ready(mem_ready), .o_ir_write(irw1), .o_pc_write(pcw1), .o_pc_write_cond(pwc1),
      .o_pc_source(pcs1), .o_mem_read(mrd1), .o_mem_write(mwr1), .o_i_or_d(iod1),
      .o_alu_src_a(asa1), .o_alu_src_b(asb1), .o_alu_ctl(alc1), .o_reg_write(rgw1),
      .o_mem_to_reg(m2r1), .o_halted(hlt1), .o_instr_count(cnt1));

   ctl_t obs0, obs1;
   assign obs0 = {irw0, pcw0, pwc0, pcs0, mrd0, mwr0, iod0, asa0, asb0, alc0, rgw0, m2r0, hlt0};
   assign obs1 = {irw1, pcw1, pwc1, pcs1, mrd1, mwr1, iod1, asa1, asb1, alc1, rgw1, m2r1, hlt1};

   int          total = 0;
   int          bad = 0;
   logic        sel;
   bit          exp_on;
   ctl_t        exp_v;
   int unsigned exp_c, model_cnt;
   ctl_t        tr_v[$];
   int unsigned tr_c[$];

   function automatic ctl_t exp_ctl(ph_t p, logic [3:0] ctl, logic rdy);
      ctl_t e;
      e = '0;
      e.alu_ctl = ADD;
      case (p)
         P_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
         P_DECODE: e.alu_src_b = 2'b10;
         P_EXR:    begin e.alu_src_a = 1; e.alu_ctl = ctl; end
         P_EXI:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctl = ctl; end
         P_MADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         P_MRD:    begin e.mem_read = 1; e.i_or_d = 1; end
         P_MWB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
         P_MWR:    begin e.mem_write = 1; e.i_or_d = 1; end
         P_AWB:    e.reg_write = 1;
         P_BR:     begin e.alu_src_a = 1; e.alu_ctl = SUB; e.pc_write_cond = 1; e.pc_source = 1; end
         P_HALT:   e.halted = 1;
         default:  e = '0;
      endcase
      return e;
   endfunction

   function automatic bit legal_op(logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011;
   endfunction

   always @(negedge clk) begin
      if (exp_on) begin
         ctl_t o;
         int unsigned c;
         o = sel ? obs1 : obs0;
         c = sel ? 32'(cnt1) : cnt0;
         total++;
         if (o !== exp_v) begin
            bad++;
            $display("FAIL ctl_vec t=%0t: got %h want %h", $time, o, exp_v);
         end
         total++;
         if (c !== exp_c) begin
            bad++;
            $display("FAIL instr_count t=%0t: got %0d want %0d", $time, c, exp_c);
         end
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic retire();
      model_cnt = (model_cnt + 1) & (sel ? 32'hF : 32'hFFFF_FFFF);
   endtask

   task automatic cyc(ph_t p, logic [3:0] ctl, logic rdy, bit rst);
      mem_ready = rdy;
      if (sel) rst1 = rst; else rst0 = rst;
      exp_v  = exp_ctl(p, ctl, rdy);
      exp_c  = model_cnt;
      exp_on = 1;
      @(negedge clk);
      #1;
      tr_v.push_back(sel ? obs1 : obs0);
      tr_c.push_back(sel ? 32'(cnt1) : cnt0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      exp_on    = 0;
      mem_ready = 1;
      if (sel) rst1 = 1; else rst0 = 1;
      repeat (2) @(posedge clk);
      #1;
      if (sel) rst1 = 0; else rst0 = 0;
      model_cnt = 0;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // kinds 0..4 add/sub/xor/or/and, 5 addi, 6 ori, 7 ld, 8 sd, 9 beq, 10 illegal
   task automatic run_instr(int kind, int fw, int mw);
      logic [2:0] r_f3[5]  = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b111};
      logic [6:0] r_f7[5]  = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
      logic [3:0] r_ctl[5] = '{4'b0010, 4'b0110, 4'b0101, 4'b0001, 4'b0000};
      tr_v.delete();
      tr_c.delete();
      funct7 = 7'($urandom);
      funct3 = 3'($urandom);
      if (kind <= 4) begin
         opcode = 7'b0110011; funct3 = r_f3[kind]; funct7 = r_f7[kind];
      end else if (kind <= 6) begin
         opcode = 7'b0010011; funct3 = (kind == 5) ? 3'b000 : 3'b110;
      end else if (kind == 7) opcode = 7'b0000011;
      else if (kind == 8) opcode = 7'b0100011;
      else if (kind == 9) begin
         opcode = 7'b1100011; funct3 = 3'b000;
      end else begin
         case ($urandom_range(0, 3))
            0: begin
               opcode = 7'($urandom);
               while (legal_op(opcode)) opcode = 7'($urandom);
            end
            1: begin opcode = 7'b0110011; funct7 = 7'b0000001; end
            2: begin
               opcode = 7'b0010011;
               while (funct3 == 3'b000 || funct3 == 3'b110) funct3 = 3'($urandom);
            end
            default: begin opcode = 7'b1100011; funct3 = 3'($urandom_range(1, 7)); end
         endcase
      end
      for (int i = 0; i < fw; i++) cyc(P_FETCH, ADD, 1'b0, 1'b0);
      cyc(P_FETCH, ADD, 1'b1, 1'b0);
      cyc(P_DECODE, ADD, rb(), 1'b0);
      if (kind <= 4) begin
         cyc(P_EXR, r_ctl[kind], rb(), 1'b0);
         cyc(P_AWB, ADD, rb(), 1'b0);
         retire();
      end else if (kind <= 6) begin
         cyc(P_EXI, (kind == 6) ? 4'b0001 : ADD, rb(), 1'b0);
         cyc(P_AWB, ADD, rb(), 1'b0);
         retire();
      end else if (kind == 7) begin
         cyc(P_MADDR, ADD, rb(), 1'b0);
         for (int i = 0; i < mw; i++) cyc(P_MRD, ADD, 1'b0, 1'b0);
         cyc(P_MRD, ADD, 1'b1, 1'b0);
         cyc(P_MWB, ADD, rb(), 1'b0);
         retire();
      end else if (kind == 8) begin
         cyc(P_MADDR, ADD, rb(), 1'b0);
         for (int i = 0; i < mw; i++) cyc(P_MWR, ADD, 1'b0, 1'b0);
         cyc(P_MWR, ADD, 1'b1, 1'b0);
         retire();
      end else if (kind == 9) begin
         cyc(P_BR, SUB, rb(), 1'b0);
         retire();
      end else if (!sel) begin
         for (int i = 0; i < 3; i++) cyc(P_HALT, ADD, rb(), 1'b0);
      end
   endtask

   initial begin
      logic [3:0] lit_ctl[5] = '{4'b0010, 4'b0110, 4'b0101, 4'b0001, 4'b0000};
      sel = 0; rst0 = 1; rst1 = 1; exp_on = 0; mem_ready = 1;
      opcode = '0; funct3 = '0; funct7 = '0; model_cnt = 0;
      @(posedge clk);
      #1;
      do_reset();

      // five R-type ops, zero-wait memory
      for (int k = 0; k < 5; k++) begin
         run_instr(k, 0, 0);
         check("exec_r_alu_ctl", 32'(tr_v[2].alu_ctl), 32'(lit_ctl[k]));
         check("alu_wb_reg_write", 32'(tr_v[3].reg_write), 32'd1);
         check("exec_r_no_reg_write", 32'(tr_v[2].reg_write), 32'd0);
         if (k == 0) begin
            check("reset_fetch_mem_read", 32'(tr_v[0].mem_read), 32'd1);
            check("reset_count_zero", tr_c[0], 32'd0);
         end
      end
      run_instr(7, 0, 3);
      check("ld_count_before", tr_c[0], 32'd5);
      check("ld_wait_mem_read", 32'(tr_v[4].mem_read), 32'd1);
      check("ld_wait_i_or_d", 32'(tr_v[5].i_or_d), 32'd1);
      check("ld_mem_wb_mem_to_reg", 32'(tr_v[7].mem_to_reg), 32'd1);
      run_instr(8, 1, 2);
      check("sd_mem_write_held", 32'(tr_v[4].mem_write & tr_v[5].mem_write & tr_v[6].mem_write), 32'd1);
      run_instr(9, 0, 0);
      check("beq_pc_write_cond", 32'(tr_v[2].pc_write_cond), 32'd1);
      check("beq_alu_ctl", 32'(tr_v[2].alu_ctl), 32'h6);
      check("beq_pc_source", 32'(tr_v[2].pc_source), 32'd1);
      check("count_after_directed", cnt0, 32'd8);
      run_instr(10, 0, 0);
      check("illegal_halted", 32'(tr_v[4].halted), 32'd1);
      check("illegal_count_frozen", tr_c[4], 32'd8);
      do_reset();

      // randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         int kind;
         kind = $urandom_range(0, 10);
         run_instr(kind, $urandom_range(0, 2), $urandom_range(0, 3));
         if (kind == 10) do_reset();
      end

      // reset while MEM_RD is waiting
      run_instr(0, 0, 0);
      tr_v.delete();
      tr_c.delete();
      opcode = 7'b0000011;
      cyc(P_FETCH, ADD, 1'b1, 1'b0);
      cyc(P_DECODE, ADD, 1'b0, 1'b0);
      cyc(P_MADDR, ADD, 1'b0, 1'b0);
      cyc(P_MRD, ADD, 1'b0, 1'b0);
      cyc(P_MRD, ADD, 1'b1, 1'b1);
      model_cnt = 0;
      cyc(P_FETCH, ADD, 1'b1, 1'b0);
      check("midwait_reset_count", tr_c[5], 32'd0);
      check("midwait_reset_fetch", 32'(tr_v[5].mem_read & ~tr_v[5].i_or_d), 32'd1);
      cyc(P_DECODE, ADD, 1'b0, 1'b0);
      cyc(P_MADDR, ADD, 1'b0, 1'b0);
      cyc(P_MRD, ADD, 1'b1, 1'b0);
      cyc(P_MWB, ADD, 1'b0, 1'b0);
      retire();

      // NOP-on-illegal variant with a 4-bit counter
      exp_on = 0;
      rst0 = 1;
      sel = 1;
      do_reset();
      run_instr(10, 0, 0);
      for (int n = 0; n < 15; n++) run_instr($urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 2));
      check("nop_illegal_fetch_after", 32'(tr_v[0].mem_read), 32'd1);
      check("count_at_max", 32'(cnt1), 32'd15);
      run_instr(9, 0, 0);
      check("count_wrap", 32'(cnt1), 32'd0);
      run_instr(10, 1, 0);
      run_instr(0, 0, 0);
      check("count_after_wrap", 32'(cnt1), 32'd1);

      exp_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
